// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: default width, opcodes, FSM states and ALU op codes.
// The opcode-to-ALU mapping helpers keep the decode in one place.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ANDN = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_ASR  = 4'hA;
  localparam logic [3:0] OP_ROL  = 4'hB;
  localparam logic [3:0] OP_ROR  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_NOR  = 4'hF;

  // Low nibble selects the function, upper bits are operand/result modifiers.
  localparam logic [6:0] ALU_ADD     = 7'h00;
  localparam logic [6:0] ALU_SUB     = 7'h01;
  localparam logic [6:0] ALU_AND     = 7'h02;
  localparam logic [6:0] ALU_OR      = 7'h03;
  localparam logic [6:0] ALU_XOR     = 7'h04;
  localparam logic [6:0] ALU_LSL     = 7'h05;
  localparam logic [6:0] ALU_LSR     = 7'h06;
  localparam logic [6:0] ALU_ASR     = 7'h07;
  localparam logic [6:0] ALU_ROL     = 7'h08;
  localparam logic [6:0] ALU_ROR     = 7'h09;
  localparam logic [6:0] ALU_INV_B   = 7'h10;
  localparam logic [6:0] ALU_INV_OUT = 7'h20;
  localparam logic [6:0] ALU_FN_MASK = 7'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [6:0] alu_op_of(input logic [3:0] opc);
    case (opc)
      OP_ADD, OP_ADC, OP_MUL: return ALU_ADD;
      OP_SUB, OP_SBC, OP_CMP: return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_ANDN: return ALU_AND | ALU_INV_B;
      OP_LSL:  return ALU_LSL;
      OP_LSR:  return ALU_LSR;
      OP_ASR:  return ALU_ASR;
      OP_ROL:  return ALU_ROL;
      OP_ROR:  return ALU_ROR;
      default: return ALU_OR | ALU_INV_OUT;
    endcase
  endfunction

  function automatic logic alu_cin_of(input logic [3:0] opc, input logic c);
    case (opc)
      OP_SUB, OP_CMP: return 1'b1;
      OP_ADC, OP_SBC: return c;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic is_arith(input logic [3:0] opc);
    return opc inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between a requester (master) and alu_seq (slave).
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_opcode;
  logic [n-1:0] in_a;
  logic [n-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_result;
  logic [3:0]   flags;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, flags
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, flags
  );
endinterface

// File: rtl/alu_seq_alu.sv
// Combinational n-bit ALU: add/sub with carry, logic, shifts/rotates, B/result inversion.
// Zero latency; no handshake. Shift amounts >= n saturate (0, or sign fill for ASR).
module alu
  import alu_seq_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [6:0]   op,
  input  logic         cin,
  output logic [n-1:0] y,
  output logic         cout,
  output logic         overflow,
  output logic         sign,
  output logic         zero
);
  localparam int SW = $clog2(n);

  logic [6:0]     fn;
  logic [n-1:0]   bx, addend, res;
  logic [n:0]     sum;
  logic [2*n-1:0] rot;
  logic [SW-1:0]  sh;
  logic           big;

  always_comb begin
    fn     = op & ALU_FN_MASK;
    bx     = ((op & ALU_INV_B) != '0) ? ~b : b;
    addend = (fn == ALU_SUB) ? ~bx : bx;
    sum    = {1'b0, a} + {1'b0, addend} + {{n{1'b0}}, cin};
    sh     = b[SW-1:0];
    big    = (b >> SW) != '0;
    rot    = '0;
    res    = '0;
    case (fn)
      ALU_ADD, ALU_SUB: res = sum[n-1:0];
      ALU_AND: res = a & bx;
      ALU_OR:  res = a | bx;
      ALU_XOR: res = a ^ bx;
      ALU_LSL: res = big ? '0 : (a << sh);
      ALU_LSR: res = big ? '0 : (a >> sh);
      ALU_ASR: begin
        // kept out of a ternary so the shift stays signed
        if (big) res = {n{a[n-1]}};
        else     res = $signed(a) >>> sh;
      end
      ALU_ROL: begin rot = {a, a} << sh; res = rot[2*n-1:n]; end
      ALU_ROR: begin rot = {a, a} >> sh; res = rot[n-1:0]; end
      default: res = '0;
    endcase
    y        = ((op & ALU_INV_OUT) != '0) ? ~res : res;
    cout     = sum[n];
    overflow = (a[n-1] == addend[n-1]) && (sum[n-1] != a[n-1]);
    sign     = y[n-1];
    zero     = (y == '0);
  end
endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU front end with {C,V,N,Z} flags and shift-add multiplier sharing one alu.
// Result 2 cycles after accept (n+1 for MUL); holds result until out_ready, accepts only when idle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  alu_seq_if.slave     bus,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [6:0]   alu_op,
  output logic         alu_cin,
  output logic [n-1:0] alu_out,
  output logic         alu_cout,
  output logic         alu_overflow,
  output logic         alu_sign,
  output logic         alu_zero
);
  localparam int CW = $clog2(n);

  state_t        state_q, state_d;
  logic [3:0]    opc_q, opc_d, flags_q, flags_d;
  logic [n-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d, acc_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_mul;

  alu #(.n(n)) u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .cin(alu_cin),
    .y(alu_out), .cout(alu_cout), .overflow(alu_overflow),
    .sign(alu_sign), .zero(alu_zero)
  );

  // In MUL, a_q is the shifting multiplicand and b_q the shifting multiplier.
  assign acc_nxt  = b_q[0] ? alu_out : acc_q;
  assign last_mul = (cnt_q == CW'(n - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d = (bus.in_opcode == OP_MUL) ? ST_MUL : ST_EXEC;
        opc_d   = bus.in_opcode;
        a_d     = bus.in_a;
        b_d     = bus.in_b;
        acc_d   = '0;
        cnt_d   = '0;
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        if (opc_q != OP_CMP) res_d = alu_out;
        flags_d = {flags_q[3:2], alu_sign, alu_zero};
        if (is_arith(opc_q)) flags_d[3:2] = {alu_cout, alu_overflow};
      end
      ST_MUL: begin
        acc_d = acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_mul) begin
          state_d = ST_DONE;
          res_d   = acc_nxt;
          flags_d = {2'b00, acc_nxt[n-1], (acc_nxt == '0)};
        end
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_a   = a_q;
    alu_b   = b_q;
    alu_op  = ALU_AND;
    alu_cin = 1'b0;
    if (!reset) begin
      if (state_q == ST_EXEC) begin
        alu_op  = alu_op_of(opc_q);
        alu_cin = alu_cin_of(opc_q, flags_q[3]);
      end else if (state_q == ST_MUL) begin
        alu_a  = acc_q;
        alu_b  = a_q;
        alu_op = ALU_ADD;
      end
    end
    bus.in_ready   = (state_q == ST_IDLE);
    bus.out_valid  = (state_q == ST_DONE);
    bus.out_result = res_q;
    bus.flags      = flags_q;
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (n=8): scoreboard of expected result/flags per request.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic [6:0]   alu_op;
  logic         alu_cin, alu_cout, alu_overflow, alu_sign, alu_zero;
  int           checks = 0;
  int           failures = 0;
  logic [N-1:0] sb_res[$];
  logic [3:0]   sb_flg[$];

  always #5 clk = ~clk;

  alu_seq_if #(.n(N)) bus ();

  alu_seq #(.n(N)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_sign(alu_sign), .alu_zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request: accept, measure latency, compare against scoreboard, optional stall, release.
  task automatic run(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                     input logic [N-1:0] b, input logic [N-1:0] er, input logic [3:0] ef,
                     input int elat, input int hold);
    int lat;
    logic [N-1:0] r;
    logic [3:0] f;
    @(negedge clk);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_a = a; bus.in_b = b;
    sb_res.push_back(er);
    sb_flg.push_back(ef);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    @(negedge clk);
    r = sb_res.pop_front();
    f = sb_flg.pop_front();
    chk({tag, "_result"}, bus.out_result, r);
    chk({tag, "_flags"}, bus.flags, f);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {bus.out_valid, bus.in_ready, bus.flags, bus.out_result},
          {1'b1, 1'b0, f, r});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_release"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_alu_drive", {alu_op, alu_cin}, {ALU_AND, 1'b0});
    chk("reset_state", {bus.in_ready, bus.out_valid, bus.flags, bus.out_result},
        {1'b1, 1'b0, 4'h0, 8'h00});
    reset = 1'b0;

    // flags are {C,V,N,Z}
    run("add_ff_01", OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b1001, 1, 0);
    run("adc_c1",    OP_ADC,  8'h01, 8'h01, 8'h03, 4'b0000, 1, 0);
    run("sub_80_01", OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b1100, 1, 0);
    run("add_1_1",   OP_ADD,  8'h01, 8'h01, 8'h02, 4'b0000, 1, 0);
    run("sbc_c0",    OP_SBC,  8'h00, 8'h00, 8'hFF, 4'b0010, 1, 0);
    run("mul_13_11", OP_MUL,  8'd13, 8'd11, 8'h8F, 4'b0010, N, 0);
    run("mul_16_16", OP_MUL,  8'd16, 8'd16, 8'h00, 4'b0001, N, 0);
    run("add_to_3c", OP_ADD,  8'hFF, 8'h3D, 8'h3C, 4'b1000, 1, 0);
    run("cmp_5_5",   OP_CMP,  8'h05, 8'h05, 8'h3C, 4'b1001, 1, 0);
    run("lsl_81_1",  OP_LSL,  8'h81, 8'h01, 8'h02, 4'b1000, 1, 0);
    run("andn",      OP_ANDN, 8'hF0, 8'h3C, 8'hC0, 4'b1010, 1, 0);
    run("nor",       OP_NOR,  8'h0F, 8'hF0, 8'h00, 4'b1001, 1, 0);
    run("asr_sat",   OP_ASR,  8'h80, 8'h09, 8'hFF, 4'b1010, 1, 0);
    run("lsr_sat",   OP_LSR,  8'h80, 8'h08, 8'h00, 4'b1001, 1, 0);
    run("ror_81_1",  OP_ROR,  8'h81, 8'h01, 8'hC0, 4'b1010, 1, 0);
    run("rol_81_1",  OP_ROL,  8'h81, 8'h01, 8'h03, 4'b1000, 1, 0);
    run("xor_hold",  OP_XOR,  8'h3C, 8'h3C, 8'h00, 4'b1001, 1, 10);

    // Abort a multiply in its third cycle; nothing from it may surface later.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = OP_MUL; bus.in_a = 8'd13; bus.in_b = 8'd11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_alu_drive", {alu_op, alu_cin}, {ALU_AND, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_state", {bus.in_ready, bus.out_valid, bus.flags, bus.out_result},
        {1'b1, 1'b0, 4'h0, 8'h00});
    repeat (12) @(negedge clk);
    chk("abort_quiet", {bus.out_valid, bus.flags, bus.out_result}, {1'b0, 4'h0, 8'h00});
    run("add_2_3",   OP_ADD,  8'h02, 8'h03, 8'h05, 4'b0000, 1, 0);

    chk("sb_empty", sb_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
